// File: rtl/register_file_1w_multi_port_read_be_pkg.sv
// Shared types and sizing helpers for the wide-write / narrow-read latch register file.
package register_file_1w_multi_port_read_be_pkg;

    // Clear sequencer state.
    typedef enum logic {
        SCM_IDLE  = 1'b0,
        SCM_CLEAR = 1'b1
    } scm_state_e;

    // Number of narrow read words packed into one wide write word.
    function automatic int unsigned scm_ratio(input int unsigned wdata_width,
                                              input int unsigned rdata_width);
        return wdata_width / rdata_width;
    endfunction

    // One byte enable per 8 bits of write data.
    function automatic int unsigned scm_be_width(input int unsigned wdata_width);
        return wdata_width / 8;
    endfunction

endpackage

// File: rtl/register_file_1w_multi_port_read_be_if.sv
// Bus bundle of the register file: N_READ narrow read ports, one wide byte-enabled
// write port, clear request and busy indication.
//   master : drives ReadEnable/ReadAddr, WriteEnable/WriteAddr/WriteData/WriteBE, Clear
//   slave  : drives ReadData/ReadValid, Busy
interface register_file_1w_multi_port_read_be_if #(
    parameter int unsigned WADDR_WIDTH = 5,
    parameter int unsigned WDATA_WIDTH = 128,
    parameter int unsigned RDATA_WIDTH = 32,
    parameter int unsigned RADDR_WIDTH = WADDR_WIDTH + $clog2(WDATA_WIDTH / RDATA_WIDTH),
    parameter int unsigned N_READ      = 4
);
    localparam int unsigned BE_WIDTH = WDATA_WIDTH / 8;

    logic [N_READ-1:0]                  ReadEnable;
    logic [N_READ-1:0][RADDR_WIDTH-1:0] ReadAddr;
    logic [N_READ-1:0][RDATA_WIDTH-1:0] ReadData;
    logic [N_READ-1:0]                  ReadValid;
    logic                               WriteEnable;
    logic [WADDR_WIDTH-1:0]             WriteAddr;
    logic [WDATA_WIDTH-1:0]             WriteData;
    logic [BE_WIDTH-1:0]                WriteBE;
    logic                               Clear;
    logic                               Busy;

    modport master (
        output ReadEnable, ReadAddr, WriteEnable, WriteAddr, WriteData, WriteBE, Clear,
        input  ReadData, ReadValid, Busy
    );

    modport slave (
        input  ReadEnable, ReadAddr, WriteEnable, WriteAddr, WriteData, WriteBE, Clear,
        output ReadData, ReadValid, Busy
    );

endinterface

// File: rtl/cluster_clock_gating.sv
// Latch-based integrated clock gate: enable captured while clk_i is low, clock passed while high.
//   clk_i     : free-running clock
//   en_i      : functional enable
//   test_en_i : scan/test override enable
//   clk_o     : gated clock
module cluster_clock_gating (
    input  logic clk_i,
    input  logic en_i,
    input  logic test_en_i,
    output logic clk_o
);
    logic en_l;

    // Transparent-low enable latch keeps clk_o glitch-free.
    always_latch begin
        if (!clk_i) begin
            en_l <= en_i | test_en_i;
        end
    end

    assign clk_o = clk_i & en_l;

endmodule

// File: rtl/register_file_1w_multi_port_read_be_clear_seq.sv
// Clear sequencer: sweeps every wide word to zero, one per cycle, after reset or on request.
//   clk, rst     : clock, synchronous active-high reset (restarts the sweep)
//   clear        : sweep request, ignored while a sweep is running
//   busy         : sweep in progress
//   clr_we       : write request of the sweep
//   clr_addr     : wide word being zeroed this cycle
//   clr_override : select zero data / all byte enables on the write path
module register_file_1w_multi_port_read_be_clear_seq
    import register_file_1w_multi_port_read_be_pkg::*;
#(
    parameter int unsigned WADDR_WIDTH = 5
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   clear,
    output logic                   busy,
    output logic                   clr_we,
    output logic [WADDR_WIDTH-1:0] clr_addr,
    output logic                   clr_override
);
    localparam logic [WADDR_WIDTH-1:0] LAST_WORD = '1;

    scm_state_e             state_q, state_d;
    logic [WADDR_WIDTH-1:0] cnt_q, cnt_d;

    // State and sweep counter registers; reset starts a fresh sweep.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= SCM_CLEAR;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next-state and counter logic.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            SCM_IDLE: begin
                if (clear) begin
                    state_d = SCM_CLEAR;
                    cnt_d   = '0;
                end
            end
            SCM_CLEAR: begin
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == LAST_WORD) begin
                    state_d = SCM_IDLE;
                end
            end
            default: begin
                state_d = SCM_CLEAR;
                cnt_d   = '0;
            end
        endcase
    end

    // Outputs decode straight from the state and counter registers.
    assign busy         = (state_q == SCM_CLEAR);
    assign clr_we       = busy;
    assign clr_addr     = cnt_q;
    assign clr_override = busy;

endmodule

// File: rtl/register_file_1w_multi_port_read_be.sv
// Latch-based register file: one wide byte-enabled write port, N_READ narrow read ports
// with one-cycle latency and a valid pulse, plus a zeroing sweep after reset or on Clear.
//   clk : clock
//   rst : synchronous active-high reset
//   bus : slave side of the register file bus (reads, write, Clear, Busy)
module register_file_1w_multi_port_read_be
    import register_file_1w_multi_port_read_be_pkg::*;
#(
    parameter int unsigned WADDR_WIDTH = 5,
    parameter int unsigned WDATA_WIDTH = 128,
    parameter int unsigned RDATA_WIDTH = 32,
    parameter int unsigned RADDR_WIDTH = WADDR_WIDTH + $clog2(WDATA_WIDTH / RDATA_WIDTH),
    parameter int unsigned N_READ      = 4
) (
    input logic                                 clk,
    input logic                                 rst,
    register_file_1w_multi_port_read_be_if.slave bus
);
    localparam int unsigned NUM_W_WORDS = 2 ** WADDR_WIDTH;
    localparam int unsigned RATIO       = scm_ratio(WDATA_WIDTH, RDATA_WIDTH);
    localparam int unsigned LOG2_RATIO  = $clog2(RATIO);
    localparam int unsigned BE_WIDTH    = scm_be_width(WDATA_WIDTH);

    logic                   busy;
    logic                   clr_we;
    logic [WADDR_WIDTH-1:0] clr_addr;
    logic                   clr_override;

    logic                   we_eff;
    logic [WADDR_WIDTH-1:0] waddr_eff;
    logic [WDATA_WIDTH-1:0] wdata_eff;
    logic [BE_WIDTH-1:0]    wbe_eff;
    logic [WDATA_WIDTH-1:0] wdata_q;
    logic                   clk_wr;

    logic [NUM_W_WORDS-1:0][WDATA_WIDTH-1:0] mem;

    logic [N_READ-1:0][RADDR_WIDTH-1:0] raddr_q;
    logic [N_READ-1:0]                  rvalid_q;
    logic [N_READ-1:0][RDATA_WIDTH-1:0] rdata_c;

    register_file_1w_multi_port_read_be_clear_seq #(
        .WADDR_WIDTH (WADDR_WIDTH)
    ) u_clear_seq (
        .clk          (clk),
        .rst          (rst),
        .clear        (bus.Clear),
        .busy         (busy),
        .clr_we       (clr_we),
        .clr_addr     (clr_addr),
        .clr_override (clr_override)
    );

    // Write source select: the sweep owns the port while busy; a Clear discards a same-cycle write.
    always_comb begin
        we_eff    = bus.WriteEnable & ~bus.Clear;
        waddr_eff = bus.WriteAddr;
        wdata_eff = bus.WriteData;
        wbe_eff   = bus.WriteBE;
        if (clr_override) begin
            we_eff    = clr_we;
            waddr_eff = clr_addr;
            wdata_eff = '0;
            wbe_eff   = '1;
        end
    end

    // Write data sample flop; the latches open in the high phase after this edge.
    always_ff @(posedge clk) begin
        if (we_eff) begin
            wdata_q <= wdata_eff;
        end
    end

    // Global gate: no write clock activity at all in cycles without a write.
    cluster_clock_gating u_cg_global (
        .clk_i     (clk),
        .en_i      (we_eff),
        .test_en_i (1'b0),
        .clk_o     (clk_wr)
    );

    // Storage: the one-hot word select is combined with the byte enable at each gate, so a
    // disabled byte never sees a clock pulse and its latch cannot pick up stale data.
    for (genvar w = 0; w < NUM_W_WORDS; w++) begin : g_word
        for (genvar b = 0; b < BE_WIDTH; b++) begin : g_byte
            logic       en_c;
            logic       gclk;
            logic [7:0] byte_q;

            assign en_c = we_eff && (waddr_eff == WADDR_WIDTH'(w)) && wbe_eff[b];

            cluster_clock_gating u_cg_byte (
                .clk_i     (clk_wr),
                .en_i      (en_c),
                .test_en_i (1'b0),
                .clk_o     (gclk)
            );

            always_latch begin
                if (gclk) begin
                    byte_q <= wdata_q[8*b +: 8];
                end
            end

            assign mem[w][8*b +: 8] = byte_q;
        end
    end

    // Read address and valid registers; requests are dropped during a sweep.
    always_ff @(posedge clk) begin
        if (rst) begin
            raddr_q  <= '0;
            rvalid_q <= '0;
        end else begin
            for (int unsigned p = 0; p < N_READ; p++) begin
                if (bus.ReadEnable[p] && !busy) begin
                    raddr_q[p] <= bus.ReadAddr[p];
                end
            end
            rvalid_q <= busy ? '0 : bus.ReadEnable;
        end
    end

    // Read mux tracks the array at the held address: upper bits pick the wide word,
    // low LOG2_RATIO bits pick the narrow slice. Forced to zero while busy.
    always_comb begin
        rdata_c = '0;
        for (int unsigned p = 0; p < N_READ; p++) begin
            if (!busy) begin
                rdata_c[p] = RDATA_WIDTH'(mem[raddr_q[p][RADDR_WIDTH-1:LOG2_RATIO]]
                             >> (RDATA_WIDTH * (32'(raddr_q[p]) % RATIO)));
            end
        end
    end

    assign bus.ReadData  = rdata_c;
    assign bus.ReadValid = rvalid_q;
    assign bus.Busy      = busy;

endmodule

// File: doc/register_file_1w_multi_port_read_be.md
Name: register_file_1w_multi_port_read_be

Overview:
- Parametrised latch-based standard-cell-memory register file: one wide write port with byte enables, N_READ narrow read ports.
- Generalises the fixed 128b/32b multi-read SCM to any power-of-two width ratio.
- Adds a read-valid handshake, a built-in clear sequencer (after reset or on request) and a busy indication.
- Sits in cluster shared-buffer / instruction-cache data arrays that are written as wide lines and read as narrow words.

Parameters:
- WADDR_WIDTH, 5, write (wide-word) address width; NUM_W_WORDS = 2**WADDR_WIDTH.
- WDATA_WIDTH, 128, write data width; multiple of RDATA_WIDTH and of 8.
- RDATA_WIDTH, 32, read data width; RATIO = WDATA_WIDTH/RDATA_WIDTH, a power of two ≥1.
- RADDR_WIDTH, WADDR_WIDTH+$clog2(RATIO), read (narrow-word) address width.
- N_READ, 4, number of independent read ports ≥1.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- ReadEnable  in  N_READ  per-port read request
- ReadAddr  in  N_READ x RADDR_WIDTH  narrow-word address
- ReadData  out  N_READ x RDATA_WIDTH  read data
- ReadValid  out  N_READ  ReadData valid for the request of the previous cycle
- WriteEnable  in  1  write request
- WriteAddr  in  WADDR_WIDTH  wide-word address
- WriteData  in  WDATA_WIDTH  write data
- WriteBE  in  WDATA_WIDTH/8  byte enables; bit b covers WriteData[8b+7:8b]
- Clear  in  1  request zeroing of the whole array
- Busy  out  1  clear sweep in progress; requests ignored

Behaviour:
- Interface (decided): one clock, clk. Reset rst is synchronous and active-high.
- Reset values, asserted in the cycle after rst is sampled high:
  - all read-address registers = 0, ReadValid = 0, ReadData = 0;
  - Busy = 1, FSM in CLEAR, sweep counter = 0.
- Storage mapping: narrow word r maps to wide word r>>log2(RATIO), slice r%RATIO. Slice 0 is bits [RDATA_WIDTH-1:0].
- Write:
  - WriteEnable is sampled in cycle N together with address, data and BE.
  - Only bytes with WriteBE=1 are updated. WriteBE=0 leaves the word unchanged, but a clock-gating pulse is still permitted.
  - Storage uses a global gate on the write enable, a one-hot per-word gate, a data sample flop and transparent-high latches.
- Read:
  - A request in cycle N registers its address. ReadData/ReadValid are presented in cycle N+1 (latency 1).
  - ReadValid is a one-cycle pulse per accepted request.
  - When ReadEnable=0, the address register holds. ReadData keeps tracking the array content at the held address, and ReadValid = 0.
- Write/read ordering:
  - A write in cycle N is visible to any read presented in cycle ≥N+1, including a read requested in the same cycle N (returns new data).
  - Multiple ports may read the same address in the same cycle; all return the same data.
- Clear FSM:
  - States: IDLE and CLEAR.
  - IDLE -> CLEAR on Clear=1. Counter resets to 0, Busy=1 from the next cycle.
  - In CLEAR, one wide word (counter value) is written to all-zero per cycle, all bytes enabled. The counter increments each cycle.
  - CLEAR -> IDLE after word NUM_W_WORDS-1 is written. Busy falls in the following cycle; the sweep lasts exactly NUM_W_WORDS cycles.
  - rst mid-sweep restarts the sweep at word 0.
  - Clear asserted while Busy is ignored; no restart.
- While Busy:
  - WriteEnable is dropped.
  - ReadEnable is dropped: address registers hold, ReadValid = 0.
  - ReadData is forced to 0.
- Clear and WriteEnable in the same IDLE cycle: the clear wins, the write is discarded and never committed.
- Addresses are always in range (power-of-two depth). There is no wrap or error condition.

Decomposition:
- Shared package scm_pkg:
  - clear-FSM state enum (SCM_IDLE, SCM_CLEAR);
  - helper localparam functions for RATIO and byte-enable width.
- Sub-module scm_clear_sequencer: FSM plus counter.
  - Outputs: Busy, an internal write request, an address and a zero-data/all-BE override. These are muxed onto the write path ahead of the gating.
- Clock gating reuses cluster_clock_gating (test_en_i tied 0).

Test Plan (default parameters: NUM_W_WORDS=32, RATIO=4, RADDR_WIDTH=7):
- Reset release -> Busy=1 for exactly 32 cycles. Reads issued during that window return ReadValid=0 and ReadData=0. Afterwards, a read of addr 127 returns 0x00000000.
- Write addr 3, data 0xDDDDDDDD_CCCCCCCC_BBBBBBBB_AAAAAAAA, BE all ones. Next cycle, ports 0..3 read 12,13,14,15 -> one cycle later ReadValid=4'b1111, data AAAAAAAA/BBBBBBBB/CCCCCCCC/DDDDDDDD.
- Write addr 3, data all-ones, BE=16'h000F -> a read of addr 12 returns 0xFFFFFFFF and addr 13 still returns 0xBBBBBBBB.
- Same cycle: write addr 5 = 0x…11223344 (slice 0) and port 2 reads addr 20 -> next cycle port 2 returns 0x11223344 with ReadValid=1.
- Clear and WriteEnable (addr 7) in the same cycle -> the write is dropped, Busy=1 for 32 cycles, every address then reads 0.
- rst pulsed at sweep cycle 10 -> Busy stays high and falls exactly 32 cycles after rst deasserts. A Clear pulse mid-sweep does not extend the sweep.
